hall_sensor_emulator: RTL
=========================

Name: hall_sensor_emulator

Overview:
- Generates the 3-bit Hall-sensor code that feeds the BLDC commutation decoder (the H input of the motor driver).
- Lets the drive chain run on the bench with no motor attached.
- Steps through the six valid 120° Hall codes at a programmable rate, in either direction.
- Tracks electrical revolutions and emits a per-step strobe for logging.

Parameters:
- CNT_W, 24, width of the step-period register and the internal interval counter.
- REV_W, 16, width of the signed electrical-revolution counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  1 = run the sequence; 0 = hold the current code.
- dir  input  1  1 = forward sequence, 0 = reverse.
- period  input  CNT_W  step interval minus one, in clk cycles.
- fault_inj  input  1  single-cycle request to inject an invalid code (see Optional Feature).
- H  output  3  emulated Hall code, registered.
- sector  output  3  current sector index, 0..5, registered.
- step  output  1  one-cycle pulse in the cycle H changes.
- erev  output  REV_W  electrical-revolution count, two's complement, registered.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Sector-to-code map:
  - 0 -> 001, 1 -> 011, 2 -> 010, 3 -> 110, 4 -> 100, 5 -> 101.
  - H always equals map(sector), except during an injected fault.
- Reset values: H = 001, sector = 0, step = 0, erev = 0, interval counter = 0, period shadow = 0, state = IDLE, fault pending = 0.
- State IDLE:
  - Counter held at 0; H and sector hold their values; step = 0.
  - When en = 1: load the period shadow from period and go to RUN.
- State RUN:
  - Counter increments every cycle.
  - When counter == period shadow, a step boundary occurs. In that same clock edge:
    - counter <= 0;
    - period shadow <= period;
    - sector advances by one position;
    - H is updated;
    - step <= 1 for exactly one cycle.
  - Step spacing is period+1 cycles.
  - First step after entering RUN occurs period+1 cycles after the IDLE->RUN edge.
  - period = 0 gives a step every cycle, and step stays high continuously.
- Direction:
  - dir is sampled only at a step boundary.
  - Forward: sector+1, with 5 wraps to 0.
  - Reverse: sector-1, with 0 wraps to 5.
- Period changes mid-interval take effect only at the next boundary, never on the current interval.
- Revolution counter:
  - Forward wrap 5->0: erev increments.
  - Reverse wrap 0->5: erev decrements.
  - Rolls over modulo 2^REV_W silently.
- en deassertion:
  - en = 0 in RUN: go to IDLE on the next edge, counter cleared, no step in that cycle, H and sector held.
  - If counter == period shadow in the same cycle that en = 0, the step is suppressed (en has priority).
- rst_n low in any state forces all reset values on the next edge; any pending fault is discarded.
- Generated code is never 000 or 111, except as specified under Optional Feature.

Optional Feature:
- Macro: HALL_FAULT_EN.
- Defined:
  - A fault_inj pulse sets a pending flag; further pulses while pending are ignored.
  - At the next step boundary, instead of advancing, H <= 000, sector holds, step pulses, erev is unchanged, and the pending flag clears.
  - The invalid code lasts exactly one interval.
  - At the following boundary the sequence resumes from the held sector, advancing normally per dir.
  - en = 0 during an invalid interval returns H to map(sector) on entry to IDLE.
- Undefined:
  - fault_inj is ignored and no pending logic is synthesised.
  - H is never invalid.

Test Plan:
- Reset, en = 0 for 10 cycles -> H = 001, sector = 0, step = 0, erev = 0 throughout.
- period = 3, dir = 1, en = 1 -> step every 4 cycles; H = 011, 010, 110, 100, 101, 001; erev = 1 after the 6th step.
- Same settings, 12 steps with dir = 0 from reset -> H = 101, 100, 110, 010, 011, 001, ...; erev = -1 (0xFFFF) after the 1st step, -2 after the 7th.
- period = 5 running, switch period to 1 two cycles after a step -> next step still 6 cycles after the previous one, later steps every 2 cycles; dir toggled mid-interval -> reversal at the next boundary only.
- en dropped in the same cycle the counter reaches period -> no step, H unchanged; en = 1 again -> first step period+1 cycles later. rst_n low mid-RUN -> H = 001, erev = 0 on the next edge.
- HALL_FAULT_EN defined, period = 2, fault_inj pulse in sector 2 -> H = 000 for 3 cycles, then H = 110; with the macro undefined -> H goes straight 010 -> 110.

Source files
------------

// File: rtl/hall_sensor_emulator.sv
// hall_sensor_emulator
//   Steps through the six valid 120-degree Hall codes at a programmable rate
//   so the BLDC commutation path can run on the bench with no motor attached.
//
//   Optional build macro: HALL_FAULT_EN
//     When defined, a fault_inj pulse replaces the next step with one interval
//     of the invalid code 000. When undefined, fault_inj is ignored.
//
//   Ports
//     clk        system clock, rising edge
//     rst_n      synchronous active-low reset
//     en         1 = run the sequence, 0 = hold the current code
//     dir        1 = forward, 0 = reverse (sampled at step boundaries only)
//     period     step interval minus one, in clk cycles
//     fault_inj  single-cycle request to inject an invalid code
//     H          emulated Hall code (registered)
//     sector     current sector 0..5 (registered)
//     step       one-cycle pulse in the cycle H changes
//     erev       signed electrical-revolution count (registered)
//
//   state | meaning
//   IDLE  | counter held at 0, code held, waiting for en
//   RUN   | interval counter running, code advances at each boundary

module hall_sensor_emulator #(
  parameter int CNT_W = 24,
  parameter int REV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic [CNT_W-1:0] period,
  input  logic             fault_inj,
  output logic [2:0]       H,
  output logic [2:0]       sector,
  output logic             step,
  output logic [REV_W-1:0] erev
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_shadow;

  logic [2:0]       sector_nxt;
  logic [REV_W-1:0] erev_nxt;

  function automatic logic [2:0] hall_map(input logic [2:0] s);
    logic [2:0] code;
    case (s)
      3'd0:    code = 3'b001;
      3'd1:    code = 3'b011;
      3'd2:    code = 3'b010;
      3'd3:    code = 3'b110;
      3'd4:    code = 3'b100;
      3'd5:    code = 3'b101;
      default: code = 3'b001;
    endcase
    return code;
  endfunction

  // Next sector and revolution count if the current boundary advances.
  always_comb begin
    sector_nxt = sector;
    erev_nxt   = erev;
    if (dir) begin
      if (sector >= 3'd5) begin
        sector_nxt = 3'd0;
        erev_nxt   = erev + 1'b1;
      end else begin
        sector_nxt = sector + 3'd1;
      end
    end else begin
      if (sector == 3'd0) begin
        sector_nxt = 3'd5;
        erev_nxt   = erev - 1'b1;
      end else begin
        sector_nxt = sector - 3'd1;
      end
    end
  end

`ifdef HALL_FAULT_EN
  logic fault_pend;
  logic fault_act;   // current interval is showing the invalid code

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      period_shadow <= '0;
      H             <= 3'b001;
      sector        <= 3'd0;
      step          <= 1'b0;
      erev          <= '0;
      fault_pend    <= 1'b0;
      fault_act     <= 1'b0;
    end else begin
      step <= 1'b0;
      if (fault_inj && !fault_pend) fault_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (en) begin
            period_shadow <= period;
            state         <= S_RUN;
          end
        end
        S_RUN: begin
          if (!en) begin
            state     <= S_IDLE;
            cnt       <= '0;
            H         <= hall_map(sector);
            fault_act <= 1'b0;
          end else if (cnt == period_shadow) begin
            cnt           <= '0;
            period_shadow <= period;
            step          <= 1'b1;
            // A fault interval always ends with a normal advance, even if a
            // new request arrived while the invalid code was showing.
            if (fault_pend && !fault_act) begin
              H          <= 3'b000;
              fault_pend <= 1'b0;
              fault_act  <= 1'b1;
            end else begin
              fault_act <= 1'b0;
              sector    <= sector_nxt;
              H         <= hall_map(sector_nxt);
              erev      <= erev_nxt;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  logic unused_fault_inj;
  assign unused_fault_inj = fault_inj;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      period_shadow <= '0;
      H             <= 3'b001;
      sector        <= 3'd0;
      step          <= 1'b0;
      erev          <= '0;
    end else begin
      step <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (en) begin
            period_shadow <= period;
            state         <= S_RUN;
          end
        end
        S_RUN: begin
          if (!en) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == period_shadow) begin
            cnt           <= '0;
            period_shadow <= period;
            step          <= 1'b1;
            sector        <= sector_nxt;
            H             <= hall_map(sector_nxt);
            erev          <= erev_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule
